// File: rtl/strat_param_ram_ctrl.sv
// Symbol-parameter RAM controller: fixed two-cycle lookups, queued byte-enabled host
// writes with write-first coherency and an optional zero-fill sweep after reset.
module strat_param_ram_ctrl #(
    parameter  int DATA_W        = 64,
    parameter  int ADDR_W        = 14,
    parameter  int WR_MODE       = 1,
    parameter  int WQ_DEPTH      = 4,
    parameter  int INIT_ON_RESET = 1,
    localparam int BE_W          = DATA_W / 8,
    localparam int LVL_W         = $clog2(WQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic              wr_done,
    output logic [ADDR_W-1:0] wr_done_addr,
    output logic              init_busy,
    output logic [LVL_W-1:0]  wq_level,
    output logic [15:0]       wr_defer_cnt
);

    localparam int PTR_W = $clog2(WQ_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++)
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep_adv;
    logic              commit, defer, accept;

    logic [DATA_W-1:0] mem    [2**ADDR_W];
    logic [ADDR_W-1:0] q_addr [WQ_DEPTH];
    logic [DATA_W-1:0] q_data [WQ_DEPTH];
    logic [BE_W-1:0]   q_be   [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [BE_W-1:0]   head_be;

    logic              vld_p0, zero_p0;
    logic [ADDR_W-1:0] addr_p0;

    assign head_addr = q_addr[rd_ptr];
    assign head_data = q_data[rd_ptr];
    assign head_be   = q_be[rd_ptr];

    assign init_busy = (state == ST_INIT);
    assign wr_ready  = !reset && (state == ST_RUN) && (wq_level < LVL_W'(WQ_DEPTH));
    assign accept    = wr_valid && wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sweep_adv = 1'b0;
        commit    = 1'b0;
        defer     = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_adv = (WR_MODE != 0) || !rd_req;
                if (sweep_adv && (sweep_addr == '1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (wq_level != '0) begin
                    if ((WR_MODE != 0) || !rd_req) commit = 1'b1;
                    else                           defer  = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_addr   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wq_level     <= '0;
            wr_defer_cnt <= '0;
            wr_done      <= 1'b0;
            wr_done_addr <= '0;
        end else begin
            if (sweep_adv) sweep_addr <= sweep_addr + ADDR_W'(1);
            if (accept)    wr_ptr     <= wr_ptr + PTR_W'(1);
            if (commit)    rd_ptr     <= rd_ptr + PTR_W'(1);
            case ({accept, commit})
                2'b10:   wq_level <= wq_level + LVL_W'(1);
                2'b01:   wq_level <= wq_level - LVL_W'(1);
                default: wq_level <= wq_level;
            endcase
            if (defer) wr_defer_cnt <= sat_inc(wr_defer_cnt);
            wr_done <= commit;
            if (commit) wr_done_addr <= head_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_addr[wr_ptr] <= wr_addr;
            q_data[wr_ptr] <= wr_data;
            q_be[wr_ptr]   <= wr_be;
        end
    end

    // A commit lands in the RAM at the same edge that captures a same-cycle lookup address,
    // so the stage-2 read below already sees it.
    always_ff @(posedge clk) begin
        if (sweep_adv)   mem[sweep_addr] <= '0;
        else if (commit) mem[head_addr]  <= be_merge(mem[head_addr], head_data, head_be);
    end

    // stage 1: register lookup address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            zero_p0 <= 1'b0;
        end else begin
            vld_p0  <= rd_req;
            zero_p0 <= (state == ST_INIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_req) addr_p0 <= rd_addr;
    end

    // stage 2: register RAM output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= vld_p0;
            if (vld_p0) rd_data <= zero_p0 ? '0 : mem[addr_p0];
        end
    end

endmodule
